count_checker: RTL and testbench

COUNT_CHECKER -- requirements
Module: count_checker

---
 rtl/count_checker_pkg.sv | 19 +
 rtl/sat_counter.sv | 25 ++
 rtl/count_checker.sv | 113 +++++++++++
 tb/tb_count_checker.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/count_checker_pkg.sv
// Shared types and constants for the count_checker block.
package count_checker_pkg;

  // Width of the saturating mismatch total.
  localparam int ERR_WIDTH = 16;

  // Checker tracking state.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // Bits needed to hold a run counter that counts up to len inclusive.
  function automatic int run_width(input int len);
    return (len < 1) ? 1 : $clog2(len + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  // Count up on inc, stick at all-ones, clear wins over a same-edge increment.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/count_checker.sv
// Watches a free-running counter for a +1 sequence: locks after LOCK_LEN
// consecutive matches, reports mismatches and wraps while locked, and drops
// lock after LOSS_LEN consecutive misses.
module count_checker
  import count_checker_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int LOCK_LEN = 4,
  parameter int LOSS_LEN = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     count_in,
  input  logic                 valid_in,
  input  logic                 clear_errors,
  output logic                 locked,
  output logic                 mismatch,
  output logic                 wrap,
  output logic [ERR_WIDTH-1:0] error_count,
  output logic [WIDTH-1:0]     expected
);

  localparam int MW = run_width(LOCK_LEN);
  localparam int LW = run_width(LOSS_LEN);
  localparam logic [MW-1:0] LOCK_CNT = MW'(LOCK_LEN);
  localparam logic [LW-1:0] LOSS_CNT = LW'(LOSS_LEN);

  state_t        state;
  logic [MW-1:0] match_run;
  logic [LW-1:0] miss_run;

  logic          hit;
  logic [MW-1:0] match_nxt;
  logic [LW-1:0] miss_nxt;
  logic          err_inc;

  assign hit       = (count_in == expected);
  assign match_nxt = match_run + MW'(1);
  assign miss_nxt  = miss_run + LW'(1);
  // Only a locked, sampled miss counts as an error.
  assign err_inc   = valid_in && (state == LOCKED) && !hit;

  // Tracking FSM with registered status outputs; idle edges hold everything.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: every register, including the run counters, has an explicit reset
    // value so the checker leaves reset in a known IDLE state.
    if (reset) begin
      state     <= IDLE;
      locked    <= 1'b0;
      mismatch  <= 1'b0;
      wrap      <= 1'b0;
      expected  <= '0;
      match_run <= '0;
      miss_run  <= '0;
    end else begin
      mismatch <= 1'b0;
      wrap     <= 1'b0;
      if (valid_in) begin
        // Next expected value always follows the last accepted sample.
        expected <= count_in + WIDTH'(1);
        unique case (state)
          IDLE: begin
            match_run <= '0;
            state     <= ACQUIRE;
          end
          ACQUIRE: begin
            if (hit) begin
              match_run <= match_nxt;
              if (match_nxt == LOCK_CNT) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                miss_run <= '0;
              end
            end else begin
              match_run <= '0;
            end
          end
          LOCKED: begin
            if (hit) begin
              miss_run <= '0;
              wrap     <= (count_in == '0);
            end else begin
              mismatch <= 1'b1;
              if (miss_nxt == LOSS_CNT) begin
                state     <= ACQUIRE;
                locked    <= 1'b0;
                match_run <= '0;
                miss_run  <= '0;
              end else begin
                miss_run <= miss_nxt;
              end
            end
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_counter #(
    .WIDTH(ERR_WIDTH)
  ) u_err_cnt (
    .clock(clock),
    .reset(reset),
    .inc  (err_inc),
    .clr  (clear_errors),
    .count(error_count)
  );

endmodule

// File: tb/tb_count_checker.sv
// Directed self-checking bench for count_checker (WIDTH=8, LOCK_LEN=4, LOSS_LEN=3).
module tb_count_checker;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  count_in = '0;
  logic        valid_in = 1'b0;
  logic        clear_errors = 1'b0;
  logic        locked, mismatch, wrap;
  logic [15:0] error_count;
  logic [7:0]  expected;

  logic        sat_inc = 1'b0;
  logic        sat_clr = 1'b0;
  logic [2:0]  sat_count;

  int tests_run = 0;
  int failed    = 0;

  always #5 clock = ~clock;

  count_checker #(.WIDTH(8), .LOCK_LEN(4), .LOSS_LEN(3)) dut (
    .clock(clock), .reset(reset), .count_in(count_in), .valid_in(valid_in),
    .clear_errors(clear_errors), .locked(locked), .mismatch(mismatch),
    .wrap(wrap), .error_count(error_count), .expected(expected)
  );

  // Small instance to reach saturation quickly.
  sat_counter #(.WIDTH(3)) u_sat (
    .clock(clock), .reset(reset), .inc(sat_inc), .clr(sat_clr), .count(sat_count)
  );

  // Called at a negedge: apply inputs, take one rising edge, return at the next negedge.
  task automatic step(input logic v, input logic [7:0] c, input logic clr);
    valid_in = v; count_in = c; clear_errors = clr;
    @(posedge clock); #1;
    valid_in = 1'b0; clear_errors = 1'b0;
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; valid_in = 1'b0; clear_errors = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    tests_run++; if (locked !== 1'b0)       begin failed++; $display("FAIL rst_locked: got %0b want 0", locked); end
    tests_run++; if (mismatch !== 1'b0)     begin failed++; $display("FAIL rst_mismatch: got %0b want 0", mismatch); end
    tests_run++; if (wrap !== 1'b0)         begin failed++; $display("FAIL rst_wrap: got %0b want 0", wrap); end
    tests_run++; if (error_count !== 16'd0) begin failed++; $display("FAIL rst_err: got %0d want 0", error_count); end
    tests_run++; if (expected !== 8'd0)     begin failed++; $display("FAIL rst_expected: got %0d want 0", expected); end
    do_reset();
  endtask

  task automatic test_lock_acquire();
    step(1'b1, 8'd10, 1'b0);
    tests_run++; if (expected !== 8'd11) begin failed++; $display("FAIL acq_seed: got %0d want 11", expected); end
    tests_run++; if (locked !== 1'b0)    begin failed++; $display("FAIL acq_seed_locked: got %0b want 0", locked); end
    step(1'b1, 8'd11, 1'b0);
    step(1'b1, 8'd12, 1'b0);
    step(1'b1, 8'd13, 1'b0);
    tests_run++; if (locked !== 1'b0)    begin failed++; $display("FAIL acq_early_lock: got %0b want 0", locked); end
    step(1'b1, 8'd14, 1'b0);
    tests_run++; if (locked !== 1'b1)    begin failed++; $display("FAIL acq_locked: got %0b want 1", locked); end
    tests_run++; if (expected !== 8'd15) begin failed++; $display("FAIL acq_expected: got %0d want 15", expected); end
    tests_run++; if (error_count !== 16'd0) begin failed++; $display("FAIL acq_err: got %0d want 0", error_count); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int v = 249; v <= 253; v++) step(1'b1, 8'(v), 1'b0);
    tests_run++; if (locked !== 1'b1)    begin failed++; $display("FAIL wrap_prelock: got %0b want 1", locked); end
    step(1'b1, 8'd254, 1'b0);
    tests_run++; if (mismatch !== 1'b0 || wrap !== 1'b0) begin failed++; $display("FAIL wrap_254: got mis=%0b wrap=%0b want 0 0", mismatch, wrap); end
    step(1'b1, 8'd255, 1'b0);
    tests_run++; if (mismatch !== 1'b0 || wrap !== 1'b0) begin failed++; $display("FAIL wrap_255: got mis=%0b wrap=%0b want 0 0", mismatch, wrap); end
    tests_run++; if (expected !== 8'd0)  begin failed++; $display("FAIL wrap_exp0: got %0d want 0", expected); end
    step(1'b1, 8'd0, 1'b0);
    tests_run++; if (wrap !== 1'b1 || mismatch !== 1'b0) begin failed++; $display("FAIL wrap_pulse: got wrap=%0b mis=%0b want 1 0", wrap, mismatch); end
    step(1'b1, 8'd1, 1'b0);
    tests_run++; if (wrap !== 1'b0)      begin failed++; $display("FAIL wrap_one_cycle: got %0b want 0", wrap); end
    tests_run++; if (error_count !== 16'd0) begin failed++; $display("FAIL wrap_err: got %0d want 0", error_count); end
  endtask

  task automatic test_glitch();
    do_reset();
    for (int v = 15; v <= 19; v++) step(1'b1, 8'(v), 1'b0);
    step(1'b1, 8'd25, 1'b0);
    tests_run++; if (mismatch !== 1'b1)  begin failed++; $display("FAIL glitch_pulse: got %0b want 1", mismatch); end
    tests_run++; if (error_count !== 16'd1) begin failed++; $display("FAIL glitch_err: got %0d want 1", error_count); end
    tests_run++; if (expected !== 8'd26) begin failed++; $display("FAIL glitch_reseed: got %0d want 26", expected); end
    step(1'b1, 8'd26, 1'b0);
    tests_run++; if (mismatch !== 1'b0)  begin failed++; $display("FAIL glitch_once: got %0b want 0", mismatch); end
    tests_run++; if (locked !== 1'b1)    begin failed++; $display("FAIL glitch_locked: got %0b want 1", locked); end
    tests_run++; if (expected !== 8'd27) begin failed++; $display("FAIL glitch_expected: got %0d want 27", expected); end
    tests_run++; if (error_count !== 16'd1) begin failed++; $display("FAIL glitch_err_hold: got %0d want 1", error_count); end
  endtask

  // Continues from the glitch scenario: locked, expecting 27, error_count 1.
  task automatic test_lock_loss();
    step(1'b1, 8'd40, 1'b0);
    tests_run++; if (mismatch !== 1'b1 || locked !== 1'b1) begin failed++; $display("FAIL loss_40: got mis=%0b lock=%0b want 1 1", mismatch, locked); end
    step(1'b1, 8'd50, 1'b0);
    tests_run++; if (mismatch !== 1'b1 || locked !== 1'b1) begin failed++; $display("FAIL loss_50: got mis=%0b lock=%0b want 1 1", mismatch, locked); end
    step(1'b1, 8'd60, 1'b0);
    tests_run++; if (mismatch !== 1'b1 || locked !== 1'b0) begin failed++; $display("FAIL loss_60: got mis=%0b lock=%0b want 1 0", mismatch, locked); end
    tests_run++; if (error_count !== 16'd4) begin failed++; $display("FAIL loss_err: got %0d want 4", error_count); end
    step(1'b1, 8'd99, 1'b0);
    tests_run++; if (mismatch !== 1'b0 || error_count !== 16'd4) begin failed++; $display("FAIL loss_acq_miss: got mis=%0b err=%0d want 0 4", mismatch, error_count); end
    tests_run++; if (expected !== 8'd100) begin failed++; $display("FAIL loss_acq_reseed: got %0d want 100", expected); end
  endtask

  task automatic test_gaps_and_clear();
    do_reset();
    for (int v = 30; v <= 34; v++) step(1'b1, 8'(v), 1'b0);
    step(1'b0, 8'd77, 1'b0);
    tests_run++; if (expected !== 8'd35 || locked !== 1'b1 || mismatch !== 1'b0) begin failed++; $display("FAIL gap_hold: got exp=%0d lock=%0b mis=%0b want 35 1 0", expected, locked, mismatch); end
    step(1'b1, 8'd35, 1'b0);
    step(1'b0, 8'd0, 1'b0);
    step(1'b0, 8'd0, 1'b0);
    step(1'b1, 8'd70, 1'b0);
    tests_run++; if (mismatch !== 1'b1 || error_count !== 16'd1) begin failed++; $display("FAIL gap_miss: got mis=%0b err=%0d want 1 1", mismatch, error_count); end
    step(1'b0, 8'd5, 1'b0);
    tests_run++; if (mismatch !== 1'b0 || expected !== 8'd71) begin failed++; $display("FAIL gap_deassert: got mis=%0b exp=%0d want 0 71", mismatch, expected); end
    step(1'b1, 8'd90, 1'b1);
    tests_run++; if (mismatch !== 1'b1) begin failed++; $display("FAIL clr_pulse: got %0b want 1", mismatch); end
    tests_run++; if (error_count !== 16'd0) begin failed++; $display("FAIL clr_priority: got %0d want 0", error_count); end
    tests_run++; if (expected !== 8'd91) begin failed++; $display("FAIL clr_expected: got %0d want 91", expected); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int v = 100; v <= 104; v++) step(1'b1, 8'(v), 1'b0);
    step(1'b1, 8'd200, 1'b0);
    tests_run++; if (locked !== 1'b1 || error_count !== 16'd1) begin failed++; $display("FAIL ar_pre: got lock=%0b err=%0d want 1 1", locked, error_count); end
    #2 reset = 1'b1;
    #1;
    tests_run++; if (locked !== 1'b0 || mismatch !== 1'b0 || wrap !== 1'b0) begin failed++; $display("FAIL ar_flags: got lock=%0b mis=%0b wrap=%0b want 0 0 0", locked, mismatch, wrap); end
    tests_run++; if (error_count !== 16'd0 || expected !== 8'd0) begin failed++; $display("FAIL ar_regs: got err=%0d exp=%0d want 0 0", error_count, expected); end
    #1 reset = 1'b0;
    @(negedge clock);
    step(1'b1, 8'd201, 1'b0);
    tests_run++; if (locked !== 1'b0 || expected !== 8'd202) begin failed++; $display("FAIL ar_seed: got lock=%0b exp=%0d want 0 202", locked, expected); end
    step(1'b1, 8'd202, 1'b0);
    step(1'b1, 8'd203, 1'b0);
    step(1'b1, 8'd204, 1'b0);
    tests_run++; if (locked !== 1'b0) begin failed++; $display("FAIL ar_early: got %0b want 0", locked); end
    step(1'b1, 8'd205, 1'b0);
    tests_run++; if (locked !== 1'b1) begin failed++; $display("FAIL ar_relock: got %0b want 1", locked); end
  endtask

  task automatic test_saturation();
    do_reset();
    @(negedge clock);
    sat_inc = 1'b1;
    repeat (9) @(posedge clock);
    #1;
    tests_run++; if (sat_count !== 3'd7) begin failed++; $display("FAIL sat_hold: got %0d want 7", sat_count); end
    sat_clr = 1'b1;
    @(posedge clock); #1;
    tests_run++; if (sat_count !== 3'd0) begin failed++; $display("FAIL sat_clr: got %0d want 0", sat_count); end
    sat_clr = 1'b0;
    @(posedge clock); #1;
    sat_inc = 1'b0;
    tests_run++; if (sat_count !== 3'd1) begin failed++; $display("FAIL sat_restart: got %0d want 1", sat_count); end
  endtask

  initial begin
    test_reset();
    test_lock_acquire();
    test_wrap();
    test_glitch();
    test_lock_loss();
    test_gaps_and_clear();
    test_async_reset();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
